stream_checker: RTL and testbench

- Synthesizable, multi-channel successor to the bench-side monitor/stabilize/capture utilities.
- Watches NUM_CH valid/ready/data streams and flags three fault classes:
  - data instability while a transfer is stalled;
  - valid retracted before the handshake completes;
  - handshake timeout.
- Optionally logs completed transfers.
- Events are timestamped, tagged with a log level and channel, and queued in an event FIFO drained by a valid/ready port. Sits beside a DUT in FPGA/emulation builds in place of the simulation-only checks.

---
 rtl/stream_checker.sv | 266 ++++++++++++++++++++++++++
 tb/tb_stream_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// Purpose: watches NUM_CH valid/ready streams and logs protocol faults or transfers as timestamped events.
// Latency: an event detected at edge E enters the event FIFO at E+1 at the earliest; evt_valid rises the cycle after.
// Backpressure: evt_ready low fills the FIFO, a full FIFO holds pending slots, and a new event on a held slot is dropped and counted.
module stream_checker #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 32,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int EVT_W     = TS_W + 3 + 2 + CH_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     info_en,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [EVT_W-1:0]         evt_data,
    output logic [15:0]              err_count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    localparam logic [1:0]  C_XFER  = 2'b00;
    localparam logic [1:0]  C_STAB  = 2'b01;
    localparam logic [1:0]  C_DROP  = 2'b10;
    localparam logic [1:0]  C_TO    = 2'b11;
    localparam logic [2:0]  L_INFO  = 3'd2;
    localparam logic [2:0]  L_ERROR = 3'd4;
    localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);
    localparam bit          TO_ONE  = (TIMEOUT == 1);
    localparam int          AW      = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [2:0]      level;
        logic [1:0]      code;
        logic [CH_W-1:0] ch;
    } evt_t;

    typedef enum logic {S_IDLE, S_WAIT} ch_state_t;

    // per-channel monitor state
    ch_state_t         st_q    [NUM_CH];
    ch_state_t         st_d    [NUM_CH];
    logic [DATA_W-1:0] ch_dat  [NUM_CH];
    logic [DATA_W-1:0] held_q  [NUM_CH];
    logic [DATA_W-1:0] held_d  [NUM_CH];
    logic [15:0]       cnt_q   [NUM_CH];
    logic [15:0]       cnt_d   [NUM_CH];
    logic [15:0]       cnt_inc [NUM_CH];
    logic [NUM_CH-1:0] derr_q, derr_d, todone_q, todone_d;
    logic [NUM_CH-1:0] stab, to_hit;
    logic [NUM_CH-1:0] det_vld;
    logic [1:0]        det_code [NUM_CH];

    // timestamp, pending slots, arbitration
    logic [TS_W-1:0]   ts_q;
    logic [NUM_CH-1:0] pend_vld_q, grant, drop;
    evt_t              pend_q [NUM_CH];
    evt_t              wr_evt;
    logic              fifo_wr_vld, fifo_wr_rdy;
    logic [4:0]        drop_n;
    logic [16:0]       drop_sum;
    logic              wr_err;

    // event FIFO storage
    evt_t              fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic [15:0]       err_q, drop_q;
    logic              ovf_q;

    // Per-channel helper terms: lane slicing, saturating stall increment, fault conditions.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_dat[i]  = ch_data[i*DATA_W +: DATA_W];
            cnt_inc[i] = (cnt_q[i] == 16'hFFFF) ? cnt_q[i] : cnt_q[i] + 16'd1;
            stab[i]    = (ch_dat[i] != held_q[i]) && !derr_q[i];
            to_hit[i]  = (cnt_inc[i] == TO_CNT) && !todone_q[i];
        end
    end

    // Channel FSM state and stall bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= S_IDLE;
                held_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            derr_q   <= '0;
            todone_q <= '0;
        end else begin
            st_q     <= st_d;
            held_q   <= held_d;
            cnt_q    <= cnt_d;
            derr_q   <= derr_d;
            todone_q <= todone_d;
        end
    end

    // Channel FSM next state: capture on stall entry, count stall cycles, leave on drop or handshake.
    always_comb begin
        st_d     = st_q;
        held_d   = held_q;
        cnt_d    = cnt_q;
        derr_d   = derr_q;
        todone_d = todone_q;
        for (int i = 0; i < NUM_CH; i++) begin
            case (st_q[i])
                S_IDLE: begin
                    if (ch_valid[i] && !ch_ready[i]) begin
                        st_d[i]     = S_WAIT;
                        held_d[i]   = ch_dat[i];
                        cnt_d[i]    = 16'd1;
                        derr_d[i]   = 1'b0;
                        todone_d[i] = TO_ONE;
                    end
                end
                default: begin
                    if (!ch_valid[i]) begin
                        st_d[i] = S_IDLE;
                    end else begin
                        // held is deliberately not refreshed so one stall reports at most one STAB_DATA
                        if (stab[i]) derr_d[i] = 1'b1;
                        if (ch_ready[i]) begin
                            st_d[i] = S_IDLE;
                        end else begin
                            cnt_d[i] = cnt_inc[i];
                            if (to_hit[i]) todone_d[i] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Channel FSM outputs: one event per channel per cycle, VALID_DROP > STAB_DATA > TIMEOUT > XFER.
    always_comb begin
        det_vld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            det_code[i] = C_XFER;
            case (st_q[i])
                S_IDLE: begin
                    if (ch_valid[i] && ch_ready[i] && info_en) begin
                        det_vld[i] = 1'b1;
                    end else if (ch_valid[i] && !ch_ready[i] && TO_ONE) begin
                        det_vld[i]  = 1'b1;
                        det_code[i] = C_TO;
                    end
                end
                default: begin
                    if (!ch_valid[i]) begin
                        det_vld[i]  = 1'b1;
                        det_code[i] = C_DROP;
                    end else if (stab[i]) begin
                        det_vld[i]  = 1'b1;
                        det_code[i] = C_STAB;
                    end else if (!ch_ready[i] && to_hit[i]) begin
                        det_vld[i]  = 1'b1;
                        det_code[i] = C_TO;
                    end else if (ch_ready[i] && info_en) begin
                        det_vld[i]  = 1'b1;
                    end
                end
            endcase
        end
    end

    // Fixed-priority arbiter: lowest occupied channel slot offers its event to the FIFO.
    always_comb begin
        fifo_wr_vld = 1'b0;
        wr_evt      = '0;
        grant       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_vld_q[i]) begin
                fifo_wr_vld = 1'b1;
                wr_evt      = pend_q[i];
                grant       = '0;
                grant[i]    = fifo_wr_rdy;
            end
        end
    end

    assign drop = det_vld & pend_vld_q & ~grant;

    // Pending slots: a draining slot can be refilled at the same edge; an occupied stalled slot keeps its event.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (det_vld[i] && (!pend_vld_q[i] || grant[i])) begin
                    pend_vld_q[i]     <= 1'b1;
                    pend_q[i].ts      <= ts_q;
                    pend_q[i].level   <= (det_code[i] == C_XFER) ? L_INFO : L_ERROR;
                    pend_q[i].code    <= det_code[i];
                    pend_q[i].ch      <= CH_W'(i);
                end else if (grant[i]) begin
                    pend_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    // Number of channels losing an event this cycle, for the saturating drop counter.
    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_CH; i++) drop_n = drop_n + 5'(drop[i]);
        drop_sum = {1'b0, drop_q} + 17'(drop_n);
    end

    // FIFO flags: a full FIFO still takes a write when it pops in the same cycle.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_pop    = !fifo_empty && evt_ready;
    assign fifo_wr_rdy = !fifo_full || evt_ready;
    assign fifo_push   = fifo_wr_vld && fifo_wr_rdy;
    assign wr_err      = fifo_push && (wr_evt.level == L_ERROR);

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= wr_evt;
    end

    // Timestamp and saturating error/drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q   <= '0;
            err_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (wr_err && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
            if (|drop) begin
                drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                ovf_q  <= 1'b1;
            end
        end
    end

    // Stale storage is masked so an empty FIFO presents all-zero data.
    assign evt_valid  = !fifo_empty;
    assign evt_data   = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign err_count  = err_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: scoreboard of expected events, compared in order as the event port drains.
// Expected events are pushed when the stimulus that causes them is driven.
// Inputs driven 1 time unit after posedge; event port sampled on negedge.
module tb_stream_checker;

    localparam int EVT_W = 39;

    logic             clk;
    logic             rst;
    logic             info_en;
    logic [3:0]       ch_valid;
    logic [3:0]       ch_ready;
    logic [31:0]      ch_data;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    logic [15:0]      err_count;
    logic [15:0]      drop_count;
    logic             overflow;

    logic [EVT_W-1:0] sb [$];
    logic [EVT_W-1:0] exp_evt;
    logic [31:0]      cyc;
    int               n_checks = 0;
    int               n_fail   = 0;

    stream_checker dut (
        .clk        (clk),
        .rst        (rst),
        .info_en    (info_en),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_data    (ch_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .err_count  (err_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference timestamp: cleared by reset, +1 per cycle.
    always @(posedge clk) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EVT_W-1:0] mk_evt(input logic [31:0] ts, input logic [2:0] lvl,
                                               input logic [1:0] code, input logic [1:0] ch);
        return {ts, lvl, code, ch};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        evt_ready = 1'b1;
        for (int k = 0; k < 60 && (sb.size() != 0 || evt_valid); k++) tick();
        repeat (4) tick();
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
        chk({tag, "_evt_valid"}, 64'(evt_valid), 64'd0);
    endtask

    // Scoreboard: every accepted event must be the next expected one.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("evt_unexpected_sb_size", 64'(sb.size()), 64'd1);
            end else begin
                exp_evt = sb.pop_front();
                chk("evt_data", 64'(evt_data), 64'(exp_evt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; info_en = 1'b0; ch_valid = '0; ch_ready = '0; ch_data = '0; evt_ready = 1'b1;
        tick(); tick();
        chk("rst_evt_valid", 64'(evt_valid), 64'd0);
        chk("rst_evt_data", 64'(evt_data), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        // ch0 single-cycle transfer at ts=5 with INFO logging on
        for (int k = 0; k < 10 && cyc != 32'd5; k++) tick();
        info_en = 1'b1; ch_valid = 4'b0001; ch_ready = 4'b0001;
        sb.push_back(mk_evt(32'd5, 3'd2, 2'b00, 2'd0));
        tick();
        ch_valid = '0; ch_ready = '0; info_en = 1'b0;
        chk("xfer_evt_valid_e1", 64'(evt_valid), 64'd0);
        tick();
        chk("xfer_evt_valid_e2", 64'(evt_valid), 64'd1);
        drain("xfer");
        chk("xfer_err_count", 64'(err_count), 64'd0);

        // ch1 stall, data changes on third stall cycle, then ready
        ch_valid = 4'b0010; ch_ready = '0; ch_data[8 +: 8] = 8'hA5;
        tick(); tick();
        ch_data[8 +: 8] = 8'h5A;
        sb.push_back(mk_evt(cyc, 3'd4, 2'b01, 2'd1));
        tick();
        ch_ready = 4'b0010;
        tick();
        ch_valid = '0; ch_ready = '0;
        drain("stab");
        chk("stab_err_count", 64'(err_count), 64'd1);

        // ch2 stalls 20 cycles: TIMEOUT at stall cycle 16, then valid dropped
        for (int k = 0; k < 20; k++) begin
            ch_valid = 4'b0100; ch_ready = '0;
            if (k == 15) sb.push_back(mk_evt(cyc, 3'd4, 2'b11, 2'd2));
            tick();
        end
        ch_valid = '0;
        sb.push_back(mk_evt(cyc, 3'd4, 2'b10, 2'd2));
        tick();
        drain("timeout");
        chk("timeout_err_count", 64'(err_count), 64'd3);

        // all four channels retract valid in the same cycle
        ch_valid = 4'b1111; ch_ready = '0;
        tick();
        ch_valid = '0;
        for (int c = 0; c < 4; c++) sb.push_back(mk_evt(cyc, 3'd4, 2'b10, 2'(c)));
        tick();
        drain("multi_drop");
        chk("multi_drop_drop_count", 64'(drop_count), 64'd0);
        chk("multi_drop_err_count", 64'(err_count), 64'd7);

        // consumer stalled: 8 events fill the FIFO, 9th held in the slot, 10th dropped
        evt_ready = 1'b0; info_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ch_valid = 4'b0001; ch_ready = 4'b0001;
            if (k < 9) sb.push_back(mk_evt(cyc, 3'd2, 2'b00, 2'd0));
            tick();
        end
        ch_valid = '0; ch_ready = '0; info_en = 1'b0;
        tick(); tick();
        chk("full_evt_valid", 64'(evt_valid), 64'd1);
        chk("full_drop_count", 64'(drop_count), 64'd1);
        chk("full_overflow", 64'(overflow), 64'd1);
        drain("full");
        chk("full_err_count", 64'(err_count), 64'd7);
        chk("full_drop_count_after", 64'(drop_count), 64'd1);

        // reset mid-stall with three events queued
        evt_ready = 1'b0; info_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ch_valid = 4'b0001; ch_ready = 4'b0001;
            tick();
        end
        info_en = 1'b0; ch_valid = 4'b1000; ch_ready = '0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_evt_valid", 64'(evt_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_evt_valid", 64'(evt_valid), 64'd0);
        chk("mid_rst_evt_data", 64'(evt_data), 64'd0);
        chk("mid_rst_err_count", 64'(err_count), 64'd0);
        chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0; evt_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) sb.push_back(mk_evt(cyc, 3'd4, 2'b11, 2'd3));
            tick();
        end
        ch_valid = '0;
        sb.push_back(mk_evt(cyc, 3'd4, 2'b10, 2'd3));
        tick();
        drain("post_rst");
        chk("post_rst_err_count", 64'(err_count), 64'd2);
        chk("post_rst_drop_count", 64'(drop_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
